// File: rtl/int_fp_mul_pipe.sv
// rtl/int_fp_mul_pipe.sv - LANES-wide 3-stage int16/fp16 multiplier with valid/ready handshake
// S1 decode+multiply, S2 normalise, S3 round/saturate/pack; the whole pipe freezes on output stall.
module int_fp_mul_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [16*LANES-1:0] in_a,
    input  logic [16*LANES-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*LANES-1:0] out_result,
    output logic [LANES-1:0]    out_overflow,
    output logic [LANES-1:0]    out_underflow,
    output logic                out_mode,
    input  logic                flag_clr,
    output logic                sticky_overflow,
    output logic                sticky_underflow,
    output logic [CNT_W-1:0]    out_count
);
    typedef enum logic [1:0] {CLS_NUM, CLS_NAN, CLS_INF, CLS_ZERO} cls_t;

    logic adv;
    logic out_xfer;
    logic s1_valid, s2_valid;
    logic s1_mode, s2_mode;

    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_mode   <= 1'b0;
            s2_mode   <= 1'b0;
            out_mode  <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            s1_mode   <= in_mode;
            s2_mode   <= s1_mode;
            out_mode  <= s2_mode;
        end
    end

    // A flag set on a transferring beat takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_overflow  <= 1'b0;
            sticky_underflow <= 1'b0;
            out_count        <= '0;
        end else begin
            if (out_xfer && (|out_overflow))
                sticky_overflow <= 1'b1;
            else if (flag_clr)
                sticky_overflow <= 1'b0;
            if (out_xfer && (|out_underflow))
                sticky_underflow <= 1'b1;
            else if (flag_clr)
                sticky_underflow <= 1'b0;
            if (out_xfer)
                out_count <= out_count + 1'b1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [15:0]        a, b;
        logic [4:0]         ea, eb;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0]        a_ext, b_ext;
        logic [21:0]        ma, mb;
        cls_t               cls_d;

        logic signed [31:0] s1_iprod;
        logic [21:0]        s1_mprod;
        logic [6:0]         s1_esum;
        logic               s1_sign;
        cls_t               s1_cls;

        logic [20:0]        norm;
        logic signed [7:0]  e_n;

        logic [15:0]        s2_ires;
        logic               s2_iov, s2_iun;
        logic signed [7:0]  s2_e;
        logic [9:0]         s2_frac;
        logic               s2_g, s2_st, s2_sign;
        cls_t               s2_cls;

        logic               rnd;
        logic [11:0]        sum;
        logic signed [7:0]  e_r;
        logic [9:0]         frac;

        logic [15:0]        res_q;
        logic               ov_q, un_q;

        assign a      = in_a[16*k +: 16];
        assign b      = in_b[16*k +: 16];
        assign ea     = a[14:10];
        assign eb     = b[14:10];
        assign a_nan  = (ea == 5'd31) && (a[9:0] != 10'd0);
        assign b_nan  = (eb == 5'd31) && (b[9:0] != 10'd0);
        assign a_inf  = (ea == 5'd31) && (a[9:0] == 10'd0);
        assign b_inf  = (eb == 5'd31) && (b[9:0] == 10'd0);
        // Subnormals are flushed: exponent zero counts as zero regardless of fraction.
        assign a_zero = (ea == 5'd0);
        assign b_zero = (eb == 5'd0);
        assign a_ext  = {{16{a[15]}}, a};
        assign b_ext  = {{16{b[15]}}, b};
        assign ma     = {11'd0, 1'b1, a[9:0]};
        assign mb     = {11'd0, 1'b1, b[9:0]};

        always_comb begin
            if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero))
                cls_d = CLS_NAN;
            else if (a_inf | b_inf)
                cls_d = CLS_INF;
            else if (a_zero | b_zero)
                cls_d = CLS_ZERO;
            else
                cls_d = CLS_NUM;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_iprod <= '0;
                s1_mprod <= '0;
                s1_esum  <= '0;
                s1_sign  <= 1'b0;
                s1_cls   <= CLS_NUM;
            end else if (adv) begin
                s1_iprod <= a_ext * b_ext;
                s1_mprod <= ma * mb;
                s1_esum  <= {2'b00, ea} + {2'b00, eb};
                s1_sign  <= a[15] ^ b[15];
                s1_cls   <= cls_d;
            end
        end

        // Mantissa product lies in [1,4); bit 21 set means it is >= 2.0.
        assign norm = s1_mprod[21] ? s1_mprod[20:0] : {s1_mprod[19:0], 1'b0};
        assign e_n  = $signed({1'b0, s1_esum}) - 8'sd15 + (s1_mprod[21] ? 8'sd1 : 8'sd0);

        always_ff @(posedge clk) begin
            if (reset) begin
                s2_ires <= '0;
                s2_iov  <= 1'b0;
                s2_iun  <= 1'b0;
                s2_e    <= '0;
                s2_frac <= '0;
                s2_g    <= 1'b0;
                s2_st   <= 1'b0;
                s2_sign <= 1'b0;
                s2_cls  <= CLS_NUM;
            end else if (adv) begin
                s2_iov  <= 1'b0;
                s2_iun  <= 1'b0;
                if (s1_iprod > 32'sd32767) begin
                    s2_ires <= 16'h7FFF;
                    s2_iov  <= 1'b1;
                end else if (s1_iprod < -32'sd32768) begin
                    s2_ires <= 16'h8000;
                    s2_iun  <= 1'b1;
                end else begin
                    s2_ires <= s1_iprod[15:0];
                end
                s2_e    <= e_n;
                s2_frac <= norm[20:11];
                s2_g    <= norm[10];
                s2_st   <= |norm[9:0];
                s2_sign <= s1_sign;
                s2_cls  <= s1_cls;
            end
        end

        assign rnd  = s2_g & (s2_st | s2_frac[0]);
        assign sum  = {2'b01, s2_frac} + {11'd0, rnd};
        assign e_r  = s2_e + (sum[11] ? 8'sd1 : 8'sd0);
        assign frac = sum[11] ? sum[10:1] : sum[9:0];

        always_ff @(posedge clk) begin
            if (reset) begin
                res_q <= '0;
                ov_q  <= 1'b0;
                un_q  <= 1'b0;
            end else if (adv) begin
                ov_q <= 1'b0;
                un_q <= 1'b0;
                if (!s2_mode) begin
                    res_q <= s2_ires;
                    ov_q  <= s2_iov;
                    un_q  <= s2_iun;
                end else begin
                    case (s2_cls)
                        CLS_NAN:  res_q <= 16'h7E00;
                        CLS_INF:  res_q <= {s2_sign, 15'h7C00};
                        CLS_ZERO: res_q <= {s2_sign, 15'd0};
                        default: begin
                            if (e_r >= 8'sd31) begin
                                res_q <= {s2_sign, 15'h7C00};
                                ov_q  <= 1'b1;
                            end else if (e_r <= 8'sd0) begin
                                res_q <= {s2_sign, 15'd0};
                                un_q  <= 1'b1;
                            end else begin
                                res_q <= {s2_sign, e_r[4:0], frac};
                            end
                        end
                    endcase
                end
            end
        end

        assign out_result[16*k +: 16] = res_q;
        assign out_overflow[k]        = ov_q;
        assign out_underflow[k]       = un_q;
    end

endmodule
